// File: rtl/bidir_shift_reg_ctl_if.sv
// ---------------------------------------------------------------------------
// bidir_shift_reg_ctl_if
//   Bundles the control, data and status signals of bidir_shift_reg_ctl.
//   Parameters:
//     N  - register width in bits
//     K  - lane width (bits moved per shift)
//     CW - lane counter width, derived from N/K
//   Signals:
//     en    - operation enable (0 = hold everything)
//     mode  - operation select
//     sin   - serial lane in (K bits)
//     pin   - parallel load data (N bits)
//     q     - register contents (N bits)
//     sout  - registered lane shifted/rotated out by the last operation
//     done  - one-cycle pulse after a full word of lanes has been shifted
//     cnt   - lanes shifted in the current word
//   Modports:
//     master - drives en/mode/sin/pin, observes q/sout/done/cnt
//     slave  - the shift register itself
// ---------------------------------------------------------------------------
interface bidir_shift_reg_ctl_if #(
  parameter int N  = 8,
  parameter int K  = 1,
  parameter int CW = ((N / K) > 2) ? $clog2(N / K) : 1
);
  logic          en;
  logic [2:0]    mode;
  logic [K-1:0]  sin;
  logic [N-1:0]  pin;
  logic [N-1:0]  q;
  logic [K-1:0]  sout;
  logic          done;
  logic [CW-1:0] cnt;

  modport master (
    output en, mode, sin, pin,
    input  q, sout, done, cnt
  );

  modport slave (
    input  en, mode, sin, pin,
    output q, sout, done, cnt
  );
endinterface

// File: rtl/bidir_shift_reg_ctl.sv
// ---------------------------------------------------------------------------
// bidir_shift_reg_ctl
//   Universal shift register moving K-bit lanes left or right, with parallel
//   load and optional rotation. The lane leaving the register is captured in
//   sout. A lane counter pulses done one cycle after every N/K-th shift step,
//   so serializer/deserializer datapaths can frame words without external
//   counting.
//
//   Ports:
//     clk   - rising-edge clock
//     reset - synchronous, active-low reset
//     bus   - bidir_shift_reg_ctl_if.slave (en, mode, sin, pin, q, sout,
//             done, cnt)
//
//   Modes: 0 HOLD, 1 SHL, 2 SHR, 3 ROL, 4 ROR, 5 LOAD, 6-7 reserved (HOLD).
//   Priority: reset > en > mode.
//
//   Build option:
//     BSR_ROTATE_EN - when defined, ROL/ROR are implemented; otherwise codes
//                     3 and 4 behave as HOLD and no rotate logic is built.
// ---------------------------------------------------------------------------
module bidir_shift_reg_ctl #(
  parameter int N = 8,
  parameter int K = 1
) (
  input logic                clk,
  input logic                reset,
  bidir_shift_reg_ctl_if.slave bus
);

  localparam int LANES = N / K;
  localparam int CW    = (LANES > 2) ? $clog2(LANES) : 1;
  localparam logic [CW-1:0] LAST_LANE = CW'(LANES - 1);

  typedef enum logic [2:0] {
    M_HOLD = 3'd0,
    M_SHL  = 3'd1,
    M_SHR  = 3'd2,
    M_ROL  = 3'd3,
    M_ROR  = 3'd4,
    M_LOAD = 3'd5
  } mode_e;

  logic [N-1:0]  q_r,    q_nxt;
  logic [K-1:0]  sout_r, sout_nxt;
  logic [CW-1:0] cnt_r,  cnt_nxt;
  logic          done_r, done_nxt;
  logic          step;

  // Next-state decode. LOAD clears the lane counter; every shift or rotate
  // is one lane step and advances it.
  // NOTE: every signal gets its hold/default value before the case so no
  // path leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    q_nxt    = q_r;
    sout_nxt = sout_r;
    cnt_nxt  = cnt_r;
    done_nxt = 1'b0;
    step     = 1'b0;

    if (bus.en) begin
      case (mode_e'(bus.mode))
        M_SHL: begin
          q_nxt    = {q_r[N-K-1:0], bus.sin};
          sout_nxt = q_r[N-1:N-K];
          step     = 1'b1;
        end
        M_SHR: begin
          q_nxt    = {bus.sin, q_r[N-1:K]};
          sout_nxt = q_r[K-1:0];
          step     = 1'b1;
        end
`ifdef BSR_ROTATE_EN
        M_ROL: begin
          q_nxt    = {q_r[N-K-1:0], q_r[N-1:N-K]};
          sout_nxt = q_r[N-1:N-K];
          step     = 1'b1;
        end
        M_ROR: begin
          q_nxt    = {q_r[K-1:0], q_r[N-1:K]};
          sout_nxt = q_r[K-1:0];
          step     = 1'b1;
        end
`endif
        M_LOAD: begin
          q_nxt   = bus.pin;
          cnt_nxt = '0;
        end
        default: ;  // HOLD, reserved codes, and rotates when not built
      endcase
    end

    // Wrap after the last lane of the word and flag it for one cycle.
    if (step) begin
      if (cnt_r == LAST_LANE) begin
        cnt_nxt  = '0;
        done_nxt = 1'b1;
      end else begin
        cnt_nxt  = cnt_r + 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      q_r    <= '0;
      sout_r <= '0;
      cnt_r  <= '0;
      done_r <= 1'b0;
    end else begin
      q_r    <= q_nxt;
      sout_r <= sout_nxt;
      cnt_r  <= cnt_nxt;
      done_r <= done_nxt;
    end
  end

  assign bus.q    = q_r;
  assign bus.sout = sout_r;
  assign bus.cnt  = cnt_r;
  assign bus.done = done_r;

endmodule

// File: tb/tb_bidir_shift_reg_ctl.sv
// ---------------------------------------------------------------------------
// tb_bidir_shift_reg_ctl
//   Directed bench for bidir_shift_reg_ctl with N = 8, K = 2. Each step
//   drives the inputs, pushes the expected register state onto a scoreboard
//   queue, and after the clock edge pops it and compares q, sout, cnt and
//   done. Rotate expectations follow BSR_ROTATE_EN.
// ---------------------------------------------------------------------------
module tb_bidir_shift_reg_ctl;

  localparam int N  = 8;
  localparam int K  = 2;
  localparam int CW = 2;

  typedef struct {
    string         tag;
    logic [N-1:0]  q;
    logic [K-1:0]  sout;
    logic [CW-1:0] cnt;
    logic          done;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  int vectors     = 0;
  int miscompares = 0;

  exp_t sb[$];

  // Reference state, updated straight from the operation table.
  logic [N-1:0]  m_q    = '0;
  logic [K-1:0]  m_sout = '0;
  logic [CW-1:0] m_cnt  = '0;
  logic          m_done = 1'b0;

  bidir_shift_reg_ctl_if #(.N(N), .K(K)) bus ();

  bidir_shift_reg_ctl #(.N(N), .K(K)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

`ifdef BSR_ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic rst_v, input logic en_v,
                       input logic [2:0] mode_v, input logic [K-1:0] sin_v,
                       input logic [N-1:0] pin_v);
    logic stepped;
    stepped = 1'b0;
    if (!rst_v) begin
      m_q = '0; m_sout = '0; m_cnt = '0; m_done = 1'b0;
      return;
    end
    m_done = 1'b0;
    if (!en_v) return;
    case (mode_v)
      3'd1: begin m_sout = m_q[7:6]; m_q = {m_q[5:0], sin_v}; stepped = 1'b1; end
      3'd2: begin m_sout = m_q[1:0]; m_q = {sin_v, m_q[7:2]}; stepped = 1'b1; end
      3'd3: if (ROT) begin m_sout = m_q[7:6]; m_q = {m_q[5:0], m_q[7:6]}; stepped = 1'b1; end
      3'd4: if (ROT) begin m_sout = m_q[1:0]; m_q = {m_q[1:0], m_q[7:2]}; stepped = 1'b1; end
      3'd5: begin m_q = pin_v; m_cnt = '0; end
      default: ;
    endcase
    if (stepped) begin
      if (m_cnt == 2'd3) begin m_cnt = '0; m_done = 1'b1; end
      else m_cnt = m_cnt + 2'd1;
    end
  endtask

  // One clock of stimulus: drive, predict, wait for the edge, compare.
  task automatic apply(input string tag, input logic rst_v, input logic en_v,
                       input logic [2:0] mode_v, input logic [K-1:0] sin_v,
                       input logic [N-1:0] pin_v);
    exp_t e;
    reset    = rst_v;
    bus.en   = en_v;
    bus.mode = mode_v;
    bus.sin  = sin_v;
    bus.pin  = pin_v;
    model(rst_v, en_v, mode_v, sin_v, pin_v);
    e.tag = tag; e.q = m_q; e.sout = m_sout; e.cnt = m_cnt; e.done = m_done;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({e.tag, "_q"},    32'(bus.q),    32'(e.q));
      check({e.tag, "_sout"}, 32'(bus.sout), 32'(e.sout));
      check({e.tag, "_cnt"},  32'(bus.cnt),  32'(e.cnt));
      check({e.tag, "_done"}, 32'(bus.done), 32'(e.done));
    end
  endtask

  initial begin
    logic [1:0] shl_sout [4];
    logic [1:0] shr_sin  [4];
    shl_sout = '{2'b10, 2'b11, 2'b01, 2'b00};
    shr_sin  = '{2'b01, 2'b10, 2'b11, 2'b00};

    bus.en = 1'b0; bus.mode = 3'd0; bus.sin = '0; bus.pin = '0;

    // Reset from power-up, then load a value and reset over it.
    apply("rst0", 1'b0, 1'b0, 3'd0, 2'b00, 8'h00);
    apply("ldA5", 1'b1, 1'b1, 3'd5, 2'b00, 8'hA5);
    check("ldA5_const_q", 32'(bus.q), 32'h0000_00A5);
    apply("shl_pre", 1'b1, 1'b1, 3'd1, 2'b11, 8'h00);
    apply("rst1", 1'b0, 1'b1, 3'd1, 2'b11, 8'h00);
    check("rst1_const_q", 32'(bus.q), 32'h0);
    check("rst1_const_cnt", 32'(bus.cnt), 32'h0);

    // SHL serialize 8'hB4.
    apply("ldB4", 1'b1, 1'b1, 3'd5, 2'b00, 8'hB4);
    for (int i = 0; i < 4; i++) begin
      apply($sformatf("shl%0d", i), 1'b1, 1'b1, 3'd1, 2'b00, 8'h00);
      check($sformatf("shl%0d_const_sout", i), 32'(bus.sout), 32'(shl_sout[i]));
      check($sformatf("shl%0d_const_done", i), 32'(bus.done), (i == 3) ? 32'd1 : 32'd0);
    end
    apply("shl_after", 1'b1, 1'b1, 3'd0, 2'b00, 8'h00);
    check("shl_after_const_q", 32'(bus.q), 32'h0);

    // SHR deserialize into 8'h39.
    for (int i = 0; i < 4; i++) begin
      apply($sformatf("shr%0d", i), 1'b1, 1'b1, 3'd2, shr_sin[i], 8'h00);
      check($sformatf("shr%0d_const_cnt", i), 32'(bus.cnt), 32'((i + 1) % 4));
    end
    check("shr_const_q", 32'(bus.q), 32'h39);

    // Rotate: back to 8'h81 with a done pulse when built, frozen otherwise.
    apply("ld81", 1'b1, 1'b1, 3'd5, 2'b00, 8'h81);
    for (int i = 0; i < 4; i++)
      apply($sformatf("rol%0d", i), 1'b1, 1'b1, 3'd3, 2'b11, 8'h00);
    check("rol_const_q", 32'(bus.q), 32'h81);
    check("rol_const_done", 32'(bus.done), ROT ? 32'd1 : 32'd0);
    for (int i = 0; i < 4; i++)
      apply($sformatf("ror%0d", i), 1'b1, 1'b1, 3'd4, 2'b11, 8'h00);
    apply("ror_mid", 1'b1, 1'b1, 3'd4, 2'b00, 8'h00);

    // Stall and LOAD-on-wrap priority.
    apply("ldC3", 1'b1, 1'b1, 3'd5, 2'b00, 8'hC3);
    apply("st_shl0", 1'b1, 1'b1, 3'd1, 2'b01, 8'h00);
    apply("st_shl1", 1'b1, 1'b1, 3'd1, 2'b10, 8'h00);
    for (int i = 0; i < 3; i++)
      apply($sformatf("stall%0d", i), 1'b1, 1'b0, 3'd1, 2'b11, 8'h00);
    check("stall_const_cnt", 32'(bus.cnt), 32'd2);
    apply("st_shr2", 1'b1, 1'b1, 3'd2, 2'b11, 8'h00);
    apply("ldFF_wrap", 1'b1, 1'b1, 3'd5, 2'b00, 8'hFF);
    check("ldFF_const_q", 32'(bus.q), 32'hFF);
    check("ldFF_const_cnt", 32'(bus.cnt), 32'd0);
    check("ldFF_const_done", 32'(bus.done), 32'd0);

    // Reserved codes and plain HOLD.
    apply("res_shl", 1'b1, 1'b1, 3'd1, 2'b00, 8'h00);
    apply("res6", 1'b1, 1'b1, 3'd6, 2'b01, 8'h12);
    apply("res7", 1'b1, 1'b1, 3'd7, 2'b10, 8'h34);
    apply("hold0", 1'b1, 1'b1, 3'd0, 2'b11, 8'h56);
    check("res_const_q", 32'(bus.q), 32'hFC);

    // Random mix, including occasional resets and stalls.
    for (int i = 0; i < 60; i++) begin
      apply($sformatf("rnd%0d", i), ($urandom_range(0, 19) != 0),
            ($urandom_range(0, 4) != 0), 3'($urandom_range(0, 7)),
            2'($urandom), 8'($urandom));
    end

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bidir_shift_reg_ctl.md
# bidir_shift_reg_ctl

Parametrised universal shift register, successor to the single-bit SISO bidirectional shifter. It shifts K-bit lanes left or right, supports parallel load and optional rotation, and exposes the departing lane as registered serial-out. A lane counter pulses `done` when a full word has been shifted, so serializer and deserializer datapaths can frame words without external counting.

## Interface
- `N`, default 8: register width in bits; N % K == 0 and N >= 2*K.
- `K`, default 1: lane width (bits moved per shift).
- `clk`  input  1  rising-edge clock.
- `reset`  input  1  synchronous, active-low reset.
- `en`  input  1  operation enable; 0 = hold everything.
- `mode`  input  3  operation select (see Operation).
- `sin`  input  K  serial lane in.
- `pin`  input  N  parallel load data.
- `q`  output  N  register contents.
- `sout`  output  K  registered lane shifted/rotated out by the last operation.
- `done`  output  1  one-cycle pulse: N/K lanes shifted since last load/wrap.
- `cnt`  output  CW  lanes shifted in current word; CW = $clog2(N/K) (min 1).

## Operation
- Mode codes: 0 HOLD, 1 SHL, 2 SHR, 3 ROL, 4 ROR, 5 LOAD, 6–7 reserved (= HOLD).
- SHL: q <= {q[N-K-1:0], sin}; sout <= q[N-1:N-K].
- SHR: q <= {sin, q[N-1:K]}; sout <= q[K-1:0].
- ROL: q <= {q[N-K-1:0], q[N-1:N-K]}; sout <= q[N-1:N-K]; `sin` ignored.
- ROR: q <= {q[K-1:0], q[N-1:K]}; sout <= q[K-1:0]; `sin` ignored.
- LOAD: q <= pin; cnt <= 0; sout unchanged; done <= 0.
- HOLD/reserved, or en = 0: q, sout, cnt held; done <= 0.
- Lane counter: each SHL/SHR/ROL/ROR with en = 1 is one step. If cnt == N/K-1, cnt <= 0 and done <= 1 next cycle; otherwise cnt <= cnt+1, done <= 0.
- Direction change mid-word does not reset cnt; only LOAD, wrap, or reset do.
- Priority: reset > en > mode.

## Timing
- All outputs registered; every effect visible one cycle after the sampling edge.
- Reset (reset = 0 at edge): q = 0, sout = 0, cnt = 0, done = 0. Reset mid-word discards progress; no done pulse.
- done is high for exactly one cycle after the N/K-th step; back-to-back words produce a done pulse every N/K enabled steps.
- Stalls (en = 0) between steps are allowed; step count is unaffected.
- LOAD on the cycle that would have wrapped: LOAD wins, no done.

## Configuration
- `BSR_ROTATE_EN` defined: ROL/ROR implemented as above.
- Undefined: codes 3 and 4 behave as HOLD (q, sout, cnt held, done 0); rotate logic not synthesised.

## Test plan
- Reset: drive q via LOAD 8'hA5 (N=8, K=2), assert reset = 0 one edge -> q = 0, sout = 0, cnt = 0, done = 0.
- SHL serialize: LOAD 8'hB4, four SHL with sin = 2'b00 -> sout sequence 2'b10, 2'b11, 2'b01, 2'b00; done high only after step 4; q = 0.
- SHR deserialize: from q = 0, four SHR with sin = 2'b01, 2'b10, 2'b11, 2'b00 -> q = 8'h39; cnt 1,2,3,0; single done pulse.
- Rotate (macro on): LOAD 8'h81, ROL x4 -> q returns to 8'h81, done pulse at step 4; macro off -> q stays 8'h81, done never asserts.
- Stall/priority: two SHL, en = 0 for 3 cycles (q, cnt = 2 held), then LOAD 8'hFF on the step-4 cycle -> q = 8'hFF, cnt = 0, no done.
- Reserved codes 6/7 with en = 1 -> no change to q/sout/cnt, done = 0.
